// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 7-segment display scanner.
//
// Scans NUM_DIGITS common-cathode-style digits (commons active-low). Each digit
// slot lasts SCAN_DIV cycles. The first cycle of each slot is a guard cycle with
// every common released and all segments off. New digit data is staged in
// shadow registers and moves to the display registers only at a frame boundary,
// so a frame is never torn. Digits can blink with a half-period of BLINK_FRAMES
// frames.
//
// Optional feature (compile-time macro LEAD_ZERO_BLANK_EN): leading zero digits
// are shown blank. Digit 0 is never blanked, and the dp is still shown.
//
// Ports:
//   CLK            clock, all state changes on the rising edge
//   RESETN         synchronous active-low reset
//   IN_VALUE       packed 4-bit digit codes, nibble i -> digit i
//   IN_LOAD        one-cycle strobe capturing IN_VALUE / IN_BLINK_MASK / IN_DP_MASK
//   IN_BLINK_MASK  per-digit blink enable
//   IN_DP_MASK     per-digit decimal point enable
//   OUT_SEG        segments, active-high, {dp, g, f, e, d, c, b, a}
//   OUT_COM        digit commons, active-low, at most one low
//   OUT_FRAME      one-cycle pulse with the first guard cycle of digit 0
module seg_scan_driver #(
  parameter int unsigned NUM_DIGITS   = 6,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  input  logic [4*NUM_DIGITS-1:0] IN_VALUE,
  input  logic                    IN_LOAD,
  input  logic [NUM_DIGITS-1:0]   IN_BLINK_MASK,
  input  logic [NUM_DIGITS-1:0]   IN_DP_MASK,
  output logic [7:0]              OUT_SEG,
  output logic [NUM_DIGITS-1:0]   OUT_COM,
  output logic                    OUT_FRAME
);

  localparam int unsigned PrescW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PrescW-1:0] PrescLast = PrescW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(NUM_DIGITS - 1);
  localparam logic [FrameW-1:0] FrameLast = FrameW'(BLINK_FRAMES - 1);

  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'h0:    glyph = 7'h3F;
      4'h1:    glyph = 7'h06;
      4'h2:    glyph = 7'h5B;
      4'h3:    glyph = 7'h4F;
      4'h4:    glyph = 7'h66;
      4'h5:    glyph = 7'h6D;
      4'h6:    glyph = 7'h7D;
      4'h7:    glyph = 7'h07;
      4'h8:    glyph = 7'h7F;
      4'h9:    glyph = 7'h6F;
      4'hA:    glyph = 7'h40;
      default: glyph = 7'h00;
    endcase
  endfunction

  logic [PrescW-1:0]       presc_q, presc_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [FrameW-1:0]       frame_cnt_q, frame_cnt_d;
  logic                    blink_q, blink_d;
  logic                    frame_start_q;
  logic [4*NUM_DIGITS-1:0] shd_val_q, shd_val_d, disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   shd_blink_q, shd_blink_d, disp_blink_q, disp_blink_d;
  logic [NUM_DIGITS-1:0]   shd_dp_q, shd_dp_d, disp_dp_q, disp_dp_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   com_q, com_d;
  logic                    frame_q;

  logic                    presc_tc, wrap;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              sel_nib;
  logic                    sel_dp, sel_blink, sel_lz;

  // Scan timing, frame/blink counters, shadow and display data.
  always_comb begin
    presc_tc     = (presc_q == PrescLast);
    wrap         = presc_tc && (idx_q == IdxLast);
    presc_d      = presc_tc ? '0 : presc_q + 1'b1;
    idx_d        = idx_q;
    frame_cnt_d  = frame_cnt_q;
    blink_d      = blink_q;
    shd_val_d    = shd_val_q;
    shd_blink_d  = shd_blink_q;
    shd_dp_d     = shd_dp_q;
    disp_val_d   = disp_val_q;
    disp_blink_d = disp_blink_q;
    disp_dp_d    = disp_dp_q;

    if (presc_tc) idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;

    if (wrap) begin
      if (frame_cnt_q == FrameLast) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
      // Old shadow moves to display; a load in this same cycle waits a frame.
      disp_val_d   = shd_val_q;
      disp_blink_d = shd_blink_q;
      disp_dp_d    = shd_dp_q;
    end

    if (IN_LOAD) begin
      shd_val_d   = IN_VALUE;
      shd_blink_d = IN_BLINK_MASK;
      shd_dp_d    = IN_DP_MASK;
    end
  end

`ifdef LEAD_ZERO_BLANK_EN
  logic seen_nz;
  // Walk from the most significant digit; blank zeros until a non-zero digit.
  always_comb begin
    lz_blank = '0;
    seen_nz  = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (disp_val_q[4*i +: 4] != 4'h0) seen_nz = 1'b1;
      lz_blank[i] = ~seen_nz;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Output decode from the current scan state; registered below.
  always_comb begin
    sel_nib   = 4'h0;
    sel_dp    = 1'b0;
    sel_blink = 1'b0;
    sel_lz    = 1'b0;
    com_d     = '1;
    seg_d     = 8'h00;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        sel_nib   = disp_val_q[4*i +: 4];
        sel_dp    = disp_dp_q[i];
        sel_blink = disp_blink_q[i];
        sel_lz    = lz_blank[i];
      end
    end
    if (presc_q != '0) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        com_d[i] = (idx_q != IdxW'(i));
      end
      if (!(blink_q && sel_blink)) begin
        seg_d[7]   = sel_dp;
        seg_d[6:0] = sel_lz ? 7'h00 : glyph(sel_nib);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      presc_q       <= '0;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      blink_q       <= 1'b0;
      frame_start_q <= 1'b0;
      shd_val_q     <= {NUM_DIGITS{4'hF}};
      shd_blink_q   <= '0;
      shd_dp_q      <= '0;
      disp_val_q    <= {NUM_DIGITS{4'hF}};
      disp_blink_q  <= '0;
      disp_dp_q     <= '0;
      seg_q         <= 8'h00;
      com_q         <= '1;
      frame_q       <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_q       <= blink_d;
      // Marks the digit-0 guard state that follows a real wrap (not reset).
      frame_start_q <= wrap;
      shd_val_q     <= shd_val_d;
      shd_blink_q   <= shd_blink_d;
      shd_dp_q      <= shd_dp_d;
      disp_val_q    <= disp_val_d;
      disp_blink_q  <= disp_blink_d;
      disp_dp_q     <= disp_dp_d;
      seg_q         <= seg_d;
      com_q         <= com_d;
      frame_q       <= frame_start_q;
    end
  end

  assign OUT_SEG   = seg_q;
  assign OUT_COM   = com_q;
  assign OUT_FRAME = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
// Cycle index k counts rising edges after reset release (k=0 is the first one);
// outputs sampled 1 time unit after edge k reflect scan state k: slot k%4,
// digit (k/4)%4, frame k/16.
module tb_seg_scan_driver;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic [15:0] IN_VALUE = 16'h0000;
  logic        IN_LOAD = 1'b0;
  logic [3:0]  IN_BLINK_MASK = 4'h0;
  logic [3:0]  IN_DP_MASK = 4'h0;
  logic [7:0]  OUT_SEG;
  logic [3:0]  OUT_COM;
  logic        OUT_FRAME;

`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [7:0] LzZero = 8'h00;
`else
  localparam logic [7:0] LzZero = 8'h3F;
`endif

  int k;
  int n_tests = 0;
  int n_fail  = 0;

  seg_scan_driver #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (4),
    .BLINK_FRAMES(2)
  ) dut (
    .CLK          (CLK),
    .RESETN       (RESETN),
    .IN_VALUE     (IN_VALUE),
    .IN_LOAD      (IN_LOAD),
    .IN_BLINK_MASK(IN_BLINK_MASK),
    .IN_DP_MASK   (IN_DP_MASK),
    .OUT_SEG      (OUT_SEG),
    .OUT_COM      (OUT_COM),
    .OUT_FRAME    (OUT_FRAME)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
    k++;
  endtask

  task automatic do_reset();
    RESETN        = 1'b0;
    IN_LOAD       = 1'b0;
    IN_VALUE      = 16'h0000;
    IN_BLINK_MASK = 4'h0;
    IN_DP_MASK    = 4'h0;
    tick();
    tick();
    RESETN = 1'b1;
    k      = -1;
  endtask

  // Expected commons for scan state kk.
  function automatic logic [3:0] exp_com(input int kk);
    logic [3:0] c;
    c = 4'hF;
    if (kk % 4 != 0) c[(kk / 4) % 4] = 1'b0;
    return c;
  endfunction

  // Expected segments for scan state kk given {d3,d2,d1,d0} glyph bytes.
  function automatic logic [7:0] exp_seg(input int kk, input logic [31:0] g);
    if (kk % 4 == 0) return 8'h00;
    return g[((kk / 4) % 4) * 8 +: 8];
  endfunction

  task automatic test_reset();
    RESETN = 1'b0;
    tick();
    tick();
    n_tests++;
    if (OUT_COM !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_com got=%b want=1111", OUT_COM);
    end
    n_tests++;
    if (OUT_SEG !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_seg got=%h want=00", OUT_SEG);
    end
    n_tests++;
    if (OUT_FRAME !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_frame got=%b want=0", OUT_FRAME);
    end
  endtask

  task automatic test_idle();
    logic ef;
    do_reset();
    for (int c = 0; c < 33; c++) begin
      tick();
      ef = (k > 0) && (k % 16 == 0);
      n_tests++;
      if (OUT_COM !== exp_com(k) || OUT_SEG !== 8'h00 || OUT_FRAME !== ef) begin
        n_fail++;
        $display("FAIL idle k=%0d com=%b seg=%h frame=%b want com=%b seg=00 frame=%b",
                 k, OUT_COM, OUT_SEG, OUT_FRAME, exp_com(k), ef);
      end
    end
  endtask

  task automatic test_load();
    logic [31:0] g;
    do_reset();
    for (int c = 0; c < 32; c++) begin
      IN_LOAD  = (k + 1 == 5);
      IN_VALUE = (k + 1 == 5) ? 16'h1234 : 16'h9999;
      tick();
      g = (k < 16) ? 32'h0 : 32'h065B4F66;
      n_tests++;
      if (OUT_COM !== exp_com(k) || OUT_SEG !== exp_seg(k, g)) begin
        n_fail++;
        $display("FAIL load k=%0d com=%b seg=%h want com=%b seg=%h",
                 k, OUT_COM, OUT_SEG, exp_com(k), exp_seg(k, g));
      end
    end
    IN_LOAD = 1'b0;
  endtask

  task automatic test_double_load();
    logic [31:0] g;
    do_reset();
    for (int c = 0; c < 48; c++) begin
      IN_LOAD = (k + 1 == 5) || (k + 1 == 20) || (k + 1 == 24);
      case (k + 1)
        5:       IN_VALUE = 16'h1234;
        20:      IN_VALUE = 16'h0012;
        24:      IN_VALUE = 16'h0034;
        default: IN_VALUE = 16'h8888;
      endcase
      tick();
      if (k < 16)      g = 32'h0;
      else if (k < 32) g = 32'h065B4F66;
      else             g = {LzZero, LzZero, 8'h4F, 8'h66};
      n_tests++;
      if (OUT_COM !== exp_com(k) || OUT_SEG !== exp_seg(k, g)) begin
        n_fail++;
        $display("FAIL double_load k=%0d com=%b seg=%h want com=%b seg=%h",
                 k, OUT_COM, OUT_SEG, exp_com(k), exp_seg(k, g));
      end
    end
    IN_LOAD = 1'b0;
  endtask

  task automatic test_wrap_load();
    logic [31:0] g;
    do_reset();
    for (int c = 0; c < 48; c++) begin
      // Edge 15 is the wrap cycle of frame 0.
      IN_LOAD  = (k + 1 == 15);
      IN_VALUE = 16'h5678;
      tick();
      g = (k < 32) ? 32'h0 : 32'h6D7D077F;
      n_tests++;
      if (OUT_COM !== exp_com(k) || OUT_SEG !== exp_seg(k, g)) begin
        n_fail++;
        $display("FAIL wrap_load k=%0d com=%b seg=%h want com=%b seg=%h",
                 k, OUT_COM, OUT_SEG, exp_com(k), exp_seg(k, g));
      end
    end
    IN_LOAD = 1'b0;
  endtask

  task automatic test_dp_lzb();
    logic [31:0] g;
    do_reset();
    for (int c = 0; c < 48; c++) begin
      IN_LOAD    = (k + 1 == 5) || (k + 1 == 20);
      IN_VALUE   = (k + 1 == 5) ? 16'h0007 : 16'h0000;
      IN_DP_MASK = (k + 1 == 5) ? 4'b0010 : 4'b0000;
      tick();
      if (k < 16)      g = 32'h0;
      else if (k < 32) g = {LzZero, LzZero, LzZero | 8'h80, 8'h07};
      else             g = {LzZero, LzZero, LzZero, 8'h3F};
      n_tests++;
      if (OUT_COM !== exp_com(k) || OUT_SEG !== exp_seg(k, g)) begin
        n_fail++;
        $display("FAIL dp_lzb k=%0d com=%b seg=%h want com=%b seg=%h",
                 k, OUT_COM, OUT_SEG, exp_com(k), exp_seg(k, g));
      end
    end
    IN_LOAD = 1'b0;
  endtask

  task automatic test_blink();
    logic [31:0] g;
    do_reset();
    for (int c = 0; c < 96; c++) begin
      IN_LOAD       = (k + 1 == 5);
      IN_VALUE      = 16'h0008;
      IN_BLINK_MASK = 4'b0001;
      IN_DP_MASK    = 4'b0001;
      tick();
      if (k < 16)                  g = 32'h0;
      else if (k >= 32 && k < 64)  g = {LzZero, LzZero, LzZero, 8'h00};
      else                         g = {LzZero, LzZero, LzZero, 8'hFF};
      n_tests++;
      if (OUT_COM !== exp_com(k) || OUT_SEG !== exp_seg(k, g)) begin
        n_fail++;
        $display("FAIL blink k=%0d com=%b seg=%h want com=%b seg=%h",
                 k, OUT_COM, OUT_SEG, exp_com(k), exp_seg(k, g));
      end
    end
    IN_LOAD       = 1'b0;
    IN_BLINK_MASK = 4'h0;
    IN_DP_MASK    = 4'h0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 27; c++) begin
      IN_LOAD  = (k + 1 == 5);
      IN_VALUE = 16'h1234;
      tick();
    end
    IN_LOAD = 1'b0;
    // k=26: frame 1, digit 2, slot 2.
    n_tests++;
    if (OUT_COM !== 4'b1011 || OUT_SEG !== 8'h5B) begin
      n_fail++;
      $display("FAIL mid_before com=%b seg=%h want com=1011 seg=5b", OUT_COM, OUT_SEG);
    end
    RESETN = 1'b0;
    tick();
    n_tests++;
    if (OUT_COM !== 4'hF || OUT_SEG !== 8'h00 || OUT_FRAME !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset com=%b seg=%h frame=%b want com=1111 seg=00 frame=0",
               OUT_COM, OUT_SEG, OUT_FRAME);
    end
    RESETN = 1'b1;
    k      = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_tests++;
      if (OUT_COM !== exp_com(k) || OUT_SEG !== 8'h00 || OUT_FRAME !== (k == 16)) begin
        n_fail++;
        $display("FAIL mid_restart k=%0d com=%b seg=%h frame=%b want com=%b seg=00",
                 k, OUT_COM, OUT_SEG, OUT_FRAME, exp_com(k));
      end
    end
  endtask

  initial begin
    k = 0;
    test_reset();
    test_idle();
    test_load();
    test_double_load();
    test_wrap_load();
    test_dp_lzb();
    test_blink();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
